// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions for the display blocks.
//   scan_state_e  : scanner FSM states {IDLE, SCAN, GAP}
//   SEG_BLANK     : all segments (and dp) dark, active-low
//   SEG_HEX_TABLE : 16-entry active-low {g,f,e,d,c,b,a} pattern per hex nibble
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low glyphs. Entry n is at index n; the listed order runs F down to 0.
  // Lit-high equivalents: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  //                       8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_display_scanner_if.sv
// Result-to-display link for seg_display_scanner.
//   in_valid / in_value / in_ovf : result offered by the ALU side
//   in_ready                     : scanner can take a result this cycle
//   seg                          : active-low {dp,g,f,e,d,c,b,a} of the lit digit
//   an                           : active-low digit enables, at most one low
// Modports: master = result source (and display observer), slave = scanner.
interface seg_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    in_valid;
  logic [4*NUM_DIGITS-1:0] in_value;
  logic                    in_ovf;
  logic                    in_ready;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output in_valid, in_value, in_ovf,
    input  in_ready, seg, an
  );

  modport slave (
    input  in_valid, in_value, in_ovf,
    output in_ready, seg, an
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder, shared by every digit through the
// scanner's digit mux.
//   nibble : hex digit to show
//   dp     : 1 lights the decimal point
//   seg    : active-low {dp,g,f,e,d,c,b,a}
module seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, SEG_HEX_TABLE[nibble]};

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed driver for a bank of common-anode 7-segment digits.
// A hex result plus overflow flag is accepted over valid/ready, latched, and
// scanned one digit at a time through a single shared decoder, with an
// all-dark gap between digits to suppress ghosting.
//
// Parameters:
//   NUM_DIGITS    digits driven; result width is 4*NUM_DIGITS
//   DIGIT_CYCLES  clk cycles each digit is lit (>= 1)
//   BLANK_CYCLES  clk cycles all digits are dark between digits (0 = no gap)
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    seg_display_scanner_if.slave: in_valid/in_value/in_ovf in,
//          in_ready/seg/an out
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero nibble show blank (their anode slot is still
//                          driven so scan timing is unchanged); digit 0 is
//                          never blanked.
module seg_display_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  seg_display_scanner_if.slave  bus
);

  localparam int VAL_W   = 4 * NUM_DIGITS;
  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_LIM = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_LIM > 1) ? $clog2(CNT_LIM) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  scan_state_e       state_p0, state_nx;
  logic [CNT_W-1:0]  cnt_p0, cnt_nx;
  logic [DIG_W-1:0]  digit_p0, digit_nx, digit_inc;
  logic              frame_end;
  logic              accept;

  logic [VAL_W-1:0]  display_p0;
  logic              display_ovf_p0;
  logic [VAL_W-1:0]  shadow_p0;
  logic              shadow_ovf_p0;
  logic              pending_p0;

  logic [3:0]        nibble;
  logic              dp_lit;
  logic [7:0]        dec_seg;
  logic              digit_blank;
  logic [7:0]        seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  logic [7:0]            seg_p1;
  logic [NUM_DIGITS-1:0] an_p1;

  // A second result can only be taken once the one waiting in the shadow
  // register has been promoted at a frame boundary.
  assign accept    = bus.in_valid & ~pending_p0;
  assign digit_inc = (digit_p0 == DIG_LAST) ? '0 : digit_p0 + 1'b1;

  // ---- stage p0: scan FSM state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      digit_p0 <= '0;
    end else begin
      state_p0 <= state_nx;
      cnt_p0   <= cnt_nx;
      digit_p0 <= digit_nx;
    end
  end

  // Next state. frame_end marks the last cycle before SCAN(0) is re-entered,
  // which is the only point where the displayed value may change while scanning.
  always_comb begin
    state_nx  = state_p0;
    cnt_nx    = cnt_p0;
    digit_nx  = digit_p0;
    frame_end = 1'b0;
    unique case (state_p0)
      IDLE: begin
        if (accept) begin
          state_nx = SCAN;
          cnt_nx   = '0;
          digit_nx = '0;
        end
      end
      SCAN: begin
        if (cnt_p0 == SCAN_LAST) begin
          cnt_nx = '0;
          if (BLANK_CYCLES == 0) begin
            digit_nx  = digit_inc;
            frame_end = (digit_p0 == DIG_LAST);
          end else begin
            state_nx = GAP;
          end
        end else begin
          cnt_nx = cnt_p0 + 1'b1;
        end
      end
      GAP: begin
        if (cnt_p0 == GAP_LAST) begin
          cnt_nx    = '0;
          state_nx  = SCAN;
          digit_nx  = digit_inc;
          frame_end = (digit_p0 == DIG_LAST);
        end else begin
          cnt_nx = cnt_p0 + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        digit_nx = '0;
      end
    endcase
  end

  // Display / shadow registers. While idle a result goes straight to the
  // display. While scanning it waits in the shadow until the frame boundary,
  // unless it arrives on the boundary cycle itself, in which case it skips
  // the shadow and is shown from the very next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      display_p0     <= '0;
      display_ovf_p0 <= 1'b0;
      shadow_p0      <= '0;
      shadow_ovf_p0  <= 1'b0;
      pending_p0     <= 1'b0;
    end else if (state_p0 == IDLE) begin
      if (accept) begin
        display_p0     <= bus.in_value;
        display_ovf_p0 <= bus.in_ovf;
      end
    end else if (frame_end) begin
      if (accept) begin
        display_p0     <= bus.in_value;
        display_ovf_p0 <= bus.in_ovf;
      end else if (pending_p0) begin
        display_p0     <= shadow_p0;
        display_ovf_p0 <= shadow_ovf_p0;
        pending_p0     <= 1'b0;
      end
    end else if (accept) begin
      shadow_p0     <= bus.in_value;
      shadow_ovf_p0 <= bus.in_ovf;
      pending_p0    <= 1'b1;
    end
  end

  // Digit mux feeding the single shared decoder.
  always_comb begin
    nibble = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_p0 == DIG_W'(i)) begin
        nibble = display_p0[4*i +: 4];
      end
    end
  end

  assign dp_lit = (digit_p0 == '0) && display_ovf_p0;

  seg_hex_decode u_hex_decode (
    .nibble (nibble),
    .dp     (dp_lit),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Index of the most significant nonzero nibble; 0 when the value is zero,
  // so digit 0 always stays visible.
  function automatic logic [DIG_W-1:0] top_digit(input logic [VAL_W-1:0] v);
    logic [DIG_W-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] != 4'h0) begin
        m = DIG_W'(i);
      end
    end
    return m;
  endfunction

  assign digit_blank = (digit_p0 > top_digit(display_p0));
`else
  assign digit_blank = 1'b0;
`endif

  // Output decode. A blanked leading digit still owns its anode slot so the
  // per-digit duty cycle does not depend on the value shown.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (state_p0 == SCAN) begin
      an_d  = ~(NUM_DIGITS'(1) << digit_p0);
      seg_d = digit_blank ? SEG_BLANK : dec_seg;
    end
  end

  // ---- stage p1: registered display pins ----
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p1 <= SEG_BLANK;
      an_p1  <= '1;
    end else begin
      seg_p1 <= seg_d;
      an_p1  <= an_d;
    end
  end

  assign bus.in_ready = ~pending_p0;
  assign bus.seg      = seg_p1;
  assign bus.an       = an_p1;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with NUM_DIGITS=4, DIGIT_CYCLES=4,
// BLANK_CYCLES=1 (20-cycle frame). Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_seg_display_scanner;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  seg_display_scanner_if #(.NUM_DIGITS(4)) bus ();

  seg_display_scanner #(
    .NUM_DIGITS   (4),
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  // Per-digit expected seg, packed {d3,d2,d1,d0}.
  localparam logic [31:0] SEG_12AF = {8'hF9, 8'hA4, 8'h88, 8'h8E};
  localparam logic [31:0] SEG_0003 = {LZ, LZ, LZ, 8'h30};
  localparam logic [31:0] SEG_4444 = {8'h99, 8'h99, 8'h99, 8'h99};
  localparam logic [31:0] SEG_5555 = {8'h92, 8'h92, 8'h92, 8'h92};
  localparam logic [31:0] SEG_0120 = {LZ, 8'hF9, 8'hA4, 8'hC0};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " an"},  {12'h000, bus.an}, 16'h000F);
    chk({tag, " seg"}, {8'h00, bus.seg},  16'h00FF);
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    chk({tag, " in_ready"}, {15'h0000, bus.in_ready}, {15'h0000, exp});
  endtask

  // Step k (1..20) of a frame: four lit cycles per digit then one dark cycle.
  task automatic frame_step(input string tag, input int k, input logic [31:0] segs);
    int pos;
    int d;
    logic [3:0] an_e;
    logic [7:0] seg_e;
    @(negedge clk);
    pos = (k - 1) % 5;
    d   = (k - 1) / 5;
    if (pos < 4) begin
      an_e  = ~(4'b0001 << d);
      seg_e = segs[8*d +: 8];
    end else begin
      an_e  = 4'hF;
      seg_e = 8'hFF;
    end
    chk($sformatf("%s an k%0d", tag, k),  {12'h000, bus.an}, {12'h000, an_e});
    chk($sformatf("%s seg k%0d", tag, k), {8'h00, bus.seg},  {8'h00, seg_e});
  endtask

  task automatic offer(input logic [15:0] v, input logic ovf);
    bus.in_valid = 1'b1;
    bus.in_value = v;
    bus.in_ovf   = ovf;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.in_ovf   = 1'b0;
    reset        = 1'b1;

    // Reset held for three edges, then idle stays dark.
    repeat (3) @(negedge clk);
    chk_dark("reset");
    chk_rdy("reset", 1'b1);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_dark("idle");
      chk_rdy("idle", 1'b1);
    end

    // 12AF from idle; outputs lag the state by one cycle.
    offer(16'h12AF, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_dark("start lag");
    chk_rdy("start", 1'b1);
    for (int k = 1; k <= 20; k++) begin
      frame_step("12AF", k, SEG_12AF);
      if (k == 19) begin
        chk_rdy("bnd pre", 1'b1);
        offer(16'h0003, 1'b1);
      end
      if (k == 20) begin
        bus.in_valid = 1'b0;
        chk_rdy("bnd bypass", 1'b1);
      end
    end

    // 0003 with overflow, committed on the boundary; then 4444 / 5555 stall.
    for (int k = 1; k <= 20; k++) begin
      frame_step("0003", k, SEG_0003);
      if (k == 5) begin
        chk_rdy("pre 4444", 1'b1);
        offer(16'h4444, 1'b0);
      end else if (k == 6) begin
        chk_rdy("pend 4444", 1'b0);
        offer(16'h5555, 1'b0);
      end else if (k > 6 && k < 20) begin
        chk_rdy($sformatf("stall k%0d", k), 1'b0);
      end else if (k == 20) begin
        chk_rdy("promote", 1'b1);
      end
    end

    // 4444 shown; 5555 went to the shadow right after the boundary.
    for (int k = 1; k <= 20; k++) begin
      frame_step("4444", k, SEG_4444);
      if (k == 1) begin
        bus.in_valid = 1'b0;
        chk_rdy("pend 5555", 1'b0);
      end
      if (k == 20) chk_rdy("promote 5555", 1'b1);
    end

    // 5555 shown; park ABCD in the shadow, then reset in the gap after digit 2.
    for (int k = 1; k <= 14; k++) begin
      frame_step("5555", k, SEG_5555);
      if (k == 3) offer(16'hABCD, 1'b1);
      if (k == 4) begin
        bus.in_valid = 1'b0;
        chk_rdy("pend ABCD", 1'b0);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    chk_dark("mid reset");
    chk_rdy("mid reset", 1'b1);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_dark("post reset idle");
      chk_rdy("post reset idle", 1'b1);
    end

    // Fresh value after reset; the discarded ABCD must never appear.
    offer(16'h0120, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_dark("restart lag");
    for (int f = 0; f < 2; f++) begin
      for (int k = 1; k <= 20; k++) begin
        frame_step($sformatf("0120 f%0d", f), k, SEG_0120);
      end
      chk_rdy("0120 end", 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
